// File: rtl/pps_cond_pkg.sv
// Shared types and widths for the PPS conditioner: FSM state encoding, counter
// widths and the saturating period-error helper.
package pps_cond_pkg;

  localparam int CNT_W    = 32;
  localparam int ERR_W    = 16;
  localparam int GLITCH_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    HOLDOVER
  } state_e;

  localparam logic signed [CNT_W:0] ERR_MAX = (CNT_W+1)'((1 << (ERR_W-1)) - 1);
  localparam logic signed [CNT_W:0] ERR_MIN = -ERR_MAX - 1;

  // Clamp a wide signed interval error into the narrow status field.
  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [CNT_W:0] v);
    if (v > ERR_MAX) begin
      sat_err = ERR_MAX[ERR_W-1:0];
    end else if (v < ERR_MIN) begin
      sat_err = ERR_MIN[ERR_W-1:0];
    end else begin
      sat_err = v[ERR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Brings the asynchronous PPS pin into the clock domain and flags each rising
// edge for exactly one cycle.
module pps_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/pps_conditioner.sv
// Qualifies PPS intervals, tracks acquisition and lock, and bridges short PPS
// outages with synthetic pulses so downstream only sees clean pulses.
module pps_conditioner
  import pps_cond_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 25_000_000,
  parameter int TOL          = 2_500,
  parameter int LOCK_COUNT   = 3,
  parameter int MAX_HOLD     = 60
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    pps_raw,
  output logic                    pps_out,
  output logic                    locked,
  output logic                    holdover,
  output logic [CNT_W-1:0]        period,
  output logic signed [ERR_W-1:0] period_err,
  output logic [GLITCH_W-1:0]     glitch_cnt
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] NOM = CNT_W'(SYS_CLK_FREQ);
  localparam logic [CNT_W-1:0] LO  = CNT_W'(SYS_CLK_FREQ - TOL);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(SYS_CLK_FREQ + TOL);

  logic edge_det;

  pps_sync_edge u_sync (
    .clk_i  (clk_in),
    .rst_i  (reset),
    .async_i(pps_raw),
    .edge_o (edge_det)
  );

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [GOOD_W-1:0]         good_q, good_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [GLITCH_W-1:0]       glitch_q, glitch_d;
  logic [CNT_W-1:0]          period_q, period_d;
  logic signed [ERR_W-1:0]   err_q, err_d;
  logic                      pps_q, pps_d;
  logic                      locked_q, holdover_q;

  logic [CNT_W-1:0]          interval;
  logic signed [CNT_W:0]     err_full;
  logic                      is_good, is_early, timeout;

  assign interval = cnt_q + CNT_W'(1);
  assign err_full = $signed({1'b0, interval}) - $signed({1'b0, NOM});
  assign is_good  = (interval >= LO) && (interval <= HI);
  assign is_early = interval < LO;
  assign timeout  = (cnt_q == HI) && !edge_det;

  // A late edge can only land on the cycle cnt reaches its ceiling; it is
  // treated like a holdover edge and restarts acquisition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
    good_d   = good_q;
    hold_d   = hold_q;
    glitch_d = glitch_q;
    period_d = period_q;
    err_d    = err_q;
    pps_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (edge_det) begin
          cnt_d = '0;
          if (!is_good) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
            state_d  = LOCKED;
            good_d   = '0;
            pps_d    = 1'b1;
            period_d = interval;
            err_d    = sat_err(err_full);
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          if (is_good) begin
            cnt_d    = '0;
            pps_d    = 1'b1;
            period_d = interval;
            err_d    = sat_err(err_full);
          end else if (is_early) begin
            if (glitch_q != '1) glitch_d = glitch_q + GLITCH_W'(1);
          end else begin
            state_d = ACQUIRE;
            good_d  = '0;
            cnt_d   = '0;
          end
        end else if (timeout) begin
          state_d = HOLDOVER;
          pps_d   = 1'b1;
          cnt_d   = '0;
          hold_d  = HOLD_W'(1);
        end
      end
      HOLDOVER: begin
        if (edge_det) begin
          state_d = ACQUIRE;
          good_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == period_q - CNT_W'(1)) begin
          cnt_d = '0;
          if (hold_q == HOLD_W'(MAX_HOLD)) begin
            state_d = IDLE;
          end else begin
            pps_d  = 1'b1;
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      good_q     <= '0;
      hold_q     <= '0;
      glitch_q   <= '0;
      period_q   <= NOM;
      err_q      <= '0;
      pps_q      <= 1'b0;
      locked_q   <= 1'b0;
      holdover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      hold_q     <= hold_d;
      glitch_q   <= glitch_d;
      period_q   <= period_d;
      err_q      <= err_d;
      pps_q      <= pps_d;
      locked_q   <= (state_d == LOCKED);
      holdover_q <= (state_d == HOLDOVER);
    end
  end

  assign pps_out    = pps_q;
  assign locked     = locked_q;
  assign holdover   = holdover_q;
  assign period     = period_q;
  assign period_err = err_q;
  assign glitch_cnt = glitch_q;

endmodule
